// File: rtl/cam_sched.sv
// Arbitrates two lookup ports and one maintenance port onto a shared key/data CAM.
// Each grant holds the CAM command, then waits for cam_outrdy, then returns a registered ack.
module cam_sched #(
  parameter int RD_WAIT   = 2,
  parameter int WR_WAIT   = 2,
  parameter int MNT_BURST = 4,
  parameter int TIMEOUT   = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  lk_req,
  input  logic [7:0]  lk_key0,
  input  logic [7:0]  lk_key1,
  output logic [1:0]  lk_ack,
  output logic [7:0]  lk_paddr,
  output logic        lk_fault,
  input  logic        mnt_req,
  input  logic        mnt_op,
  input  logic [7:0]  mnt_key,
  input  logic [7:0]  mnt_data,
  output logic        mnt_ack,
  output logic [1:0]  cam_cmd,
  output logic [7:0]  cam_key,
  output logic [7:0]  cam_datain,
  input  logic [7:0]  cam_dataout,
  input  logic        cam_outvalid,
  input  logic        cam_pagefault,
  input  logic        cam_outrdy,
  output logic        err,
  output logic [15:0] miss_cnt
);

  localparam logic [1:0] CMD_NOP = 2'b00;
  localparam logic [1:0] CMD_INS = 2'b01;
  localparam logic [1:0] CMD_DEL = 2'b10;
  localparam logic [1:0] CMD_RD  = 2'b11;
  localparam int BW = $clog2(MNT_BURST + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RELEASE, RESP} state_t;

  state_t        state;
  logic [15:0]   cnt;
  logic          is_lk;
  logic          port;
  logic          hit;
  logic [7:0]    hit_data;
  logic [BW-1:0] burst_cnt;
  logic          rr_last;

  // Miss is decided by cam_outvalid alone; the CAM's own fault flag carries no extra information.
  logic unused_pagefault;
  assign unused_pagefault = cam_pagefault;

  logic lk_any;
  logic mnt_win;
  logic lk_port;
  logic timed_out;
  logic lk_flt;
  logic [15:0] issue_last;

  assign lk_any     = |lk_req;
  assign mnt_win    = mnt_req && !(lk_any && (burst_cnt >= BW'(MNT_BURST)));
  assign lk_port    = (lk_req == 2'b11) ? ~rr_last : lk_req[1];
  assign timed_out  = !cam_outrdy;
  assign lk_flt     = timed_out || !hit;
  assign issue_last = is_lk ? 16'(RD_WAIT - 1) : 16'(WR_WAIT - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      is_lk      <= 1'b0;
      port       <= 1'b0;
      hit        <= 1'b0;
      hit_data   <= '0;
      burst_cnt  <= '0;
      rr_last    <= 1'b1;
      lk_ack     <= '0;
      mnt_ack    <= 1'b0;
      lk_paddr   <= '0;
      lk_fault   <= 1'b0;
      cam_cmd    <= CMD_NOP;
      cam_key    <= '0;
      cam_datain <= '0;
      err        <= 1'b0;
      miss_cnt   <= '0;
    end else begin
      lk_ack  <= '0;
      mnt_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (cam_outrdy && (mnt_req || lk_any)) begin
            cnt   <= '0;
            state <= ISSUE;
            if (mnt_win) begin
              is_lk      <= 1'b0;
              cam_cmd    <= mnt_op ? CMD_DEL : CMD_INS;
              cam_key    <= mnt_key;
              cam_datain <= mnt_op ? 8'h00 : mnt_data;
              if (burst_cnt < BW'(MNT_BURST))
                burst_cnt <= burst_cnt + BW'(1);
            end else begin
              is_lk      <= 1'b1;
              port       <= lk_port;
              rr_last    <= lk_port;
              burst_cnt  <= '0;
              cam_cmd    <= CMD_RD;
              cam_key    <= lk_port ? lk_key1 : lk_key0;
              cam_datain <= 8'h00;
            end
          end
        end
        ISSUE: begin
          cnt <= cnt + 16'd1;
          if (cnt == issue_last) begin
            if (is_lk) begin
              hit      <= cam_outvalid;
              hit_data <= cam_dataout;
            end
            cam_cmd    <= CMD_NOP;
            cam_key    <= '0;
            cam_datain <= '0;
            cnt        <= '0;
            state      <= RELEASE;
          end
        end
        RELEASE: begin
          cnt <= cnt + 16'd1;
          // The NOP cycle is guaranteed by entering here; leave on ready or on watchdog expiry.
          if (cam_outrdy || (cnt == 16'(TIMEOUT - 1))) begin
            state <= RESP;
            if (timed_out)
              err <= 1'b1;
            if (is_lk) begin
              lk_ack[port] <= 1'b1;
              lk_fault     <= lk_flt;
              lk_paddr     <= lk_flt ? 8'h00 : hit_data;
              if (lk_flt && (miss_cnt != 16'hFFFF))
                miss_cnt <= miss_cnt + 16'd1;
            end else begin
              mnt_ack <= 1'b1;
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_sched.sv
// Directed and randomized bench for cam_sched with a 32-entry CAM model and a key->data map reference.
module tb_cam_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  lk_req;
  logic [7:0]  lk_key0, lk_key1;
  logic [1:0]  lk_ack;
  logic [7:0]  lk_paddr;
  logic        lk_fault;
  logic        mnt_req, mnt_op;
  logic [7:0]  mnt_key, mnt_data;
  logic        mnt_ack;
  logic [1:0]  cam_cmd;
  logic [7:0]  cam_key, cam_datain;
  logic [7:0]  cam_dataout;
  logic        cam_outvalid, cam_pagefault, cam_outrdy;
  logic        err;
  logic [15:0] miss_cnt;

  always #5 clk = ~clk;

  cam_sched dut (
    .clk(clk), .rst(rst),
    .lk_req(lk_req), .lk_key0(lk_key0), .lk_key1(lk_key1),
    .lk_ack(lk_ack), .lk_paddr(lk_paddr), .lk_fault(lk_fault),
    .mnt_req(mnt_req), .mnt_op(mnt_op), .mnt_key(mnt_key), .mnt_data(mnt_data),
    .mnt_ack(mnt_ack),
    .cam_cmd(cam_cmd), .cam_key(cam_key), .cam_datain(cam_datain),
    .cam_dataout(cam_dataout), .cam_outvalid(cam_outvalid),
    .cam_pagefault(cam_pagefault), .cam_outrdy(cam_outrdy),
    .err(err), .miss_cnt(miss_cnt)
  );

  // CAM model: 32 entries, writes on INS/DEL edges, combinational read while RD is driven.
  logic [7:0] cm_key [32];
  logic [7:0] cm_dat [32];
  bit         cm_v   [32];
  bit         hang_mode = 1'b0;
  bit         hang_hold = 1'b0;
  bit         rand_mode = 1'b0;
  bit         stall = 1'b0;

  always @(posedge clk) begin : cam_write
    int idx;
    idx = -1;
    if (cam_cmd == 2'b01) begin
      for (int i = 0; i < 32; i++) if (cm_v[i] && cm_key[i] == cam_key) idx = i;
      if (idx < 0) for (int i = 31; i >= 0; i--) if (!cm_v[i]) idx = i;
      if (idx >= 0) begin
        cm_v[idx]   <= 1'b1;
        cm_key[idx] <= cam_key;
        cm_dat[idx] <= cam_datain;
      end
    end else if (cam_cmd == 2'b10) begin
      for (int i = 0; i < 32; i++) if (cm_v[i] && cm_key[i] == cam_key) cm_v[i] <= 1'b0;
    end
    if (!hang_mode) hang_hold <= 1'b0;
    else if (cam_cmd == 2'b11) hang_hold <= 1'b1;
  end

  always @(negedge clk) stall <= rand_mode && ($urandom_range(0, 3) == 0);

  always_comb begin
    cam_dataout  = 8'h00;
    cam_outvalid = 1'b0;
    if (cam_cmd == 2'b11)
      for (int i = 0; i < 32; i++)
        if (cm_v[i] && cm_key[i] == cam_key) begin
          cam_dataout  = cm_dat[i];
          cam_outvalid = 1'b1;
        end
  end
  assign cam_pagefault = (cam_cmd == 2'b11) && !cam_outvalid;
  assign cam_outrdy    = !(hang_hold || stall);

  // Ack monitor: which requester was acked, when, and with what fault flag.
  int cyc = 0;
  int n_lk = 0, n_mnt = 0;
  int log_id[$];
  int log_cyc[$];
  int log_flt[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (lk_ack[0]) begin log_id.push_back(0); log_cyc.push_back(cyc); log_flt.push_back(int'(lk_fault)); n_lk <= n_lk + 1; end
    if (lk_ack[1]) begin log_id.push_back(1); log_cyc.push_back(cyc); log_flt.push_back(int'(lk_fault)); n_lk <= n_lk + 1; end
    if (mnt_ack)   begin log_id.push_back(2); log_cyc.push_back(cyc); log_flt.push_back(0); n_mnt <= n_mnt + 1; end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: what the CAM should hold, as a plain key->data map.
  logic [7:0] ref_dat [logic [7:0]];
  int exp_miss = 0;

  logic [7:0] r_pa;
  logic       r_flt;
  int         r_lat;
  logic [1:0] r_cmd [3];

  task automatic do_lookup(input int p, input logic [7:0] key);
    int n;
    @(posedge clk); #1;
    if (p == 0) lk_key0 = key; else lk_key1 = key;
    lk_req[p] = 1'b1;
    n = 0; r_lat = -1;
    while (n < 100 && r_lat < 0) begin
      @(posedge clk); #1; n++;
      if (n <= 3) r_cmd[n-1] = cam_cmd;
      if (lk_ack[p]) begin r_lat = n; r_pa = lk_paddr; r_flt = lk_fault; end
    end
    lk_req[p] = 1'b0;
    chk("lk_ack_seen", 32'(r_lat > 0), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic do_mnt(input logic op, input logic [7:0] key, input logic [7:0] dat);
    int n;
    @(posedge clk); #1;
    mnt_op = op; mnt_key = key; mnt_data = dat; mnt_req = 1'b1;
    n = 0; r_lat = -1;
    while (n < 100 && r_lat < 0) begin
      @(posedge clk); #1; n++;
      if (n <= 3) r_cmd[n-1] = cam_cmd;
      if (mnt_ack) r_lat = n;
    end
    mnt_req = 1'b0;
    chk("mnt_ack_seen", 32'(r_lat > 0), 32'd1);
    if (op) ref_dat.delete(key); else ref_dat[key] = dat;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_miss = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd"},   32'(cam_cmd),    32'd0);
    chk({tag, "_key"},   32'(cam_key),    32'd0);
    chk({tag, "_din"},   32'(cam_datain), 32'd0);
    chk({tag, "_lkack"}, 32'(lk_ack),     32'd0);
    chk({tag, "_mack"},  32'(mnt_ack),    32'd0);
    chk({tag, "_pa"},    32'(lk_paddr),   32'd0);
    chk({tag, "_flt"},   32'(lk_fault),   32'd0);
    chk({tag, "_err"},   32'(err),        32'd0);
    chk({tag, "_miss"},  32'(miss_cnt),   32'd0);
  endtask

  initial begin
    int n, m0, l0, k, p;
    logic [7:0] keys [8];
    logic [7:0] key, dat;
    rst = 1'b1; lk_req = 2'b00; lk_key0 = 8'h00; lk_key1 = 8'h00;
    mnt_req = 1'b0; mnt_op = 1'b0; mnt_key = 8'h00; mnt_data = 8'h00;
    keys[0] = 8'h12; keys[1] = 8'h30; keys[2] = 8'h40; keys[3] = 8'h55;
    keys[4] = 8'h77; keys[5] = 8'h81; keys[6] = 8'h9A; keys[7] = 8'hC3;
    #13;
    chk_reset_outputs("rst");
    @(posedge clk); #1 rst = 1'b0;

    // Preload 0x12 -> 0xA5 through the maintenance port.
    m0 = n_mnt;
    do_mnt(1'b0, 8'h12, 8'hA5);
    chk("ins_lat", 32'(r_lat), 32'd4);
    chk("ins_cmd1", 32'(r_cmd[0]), 32'd1);
    chk("ins_cmd2", 32'(r_cmd[1]), 32'd1);
    chk("ins_cmd3", 32'(r_cmd[2]), 32'd0);
    chk("ins_once", 32'(n_mnt - m0), 32'd1);

    do_lookup(0, 8'h12);
    chk("hit_lat", 32'(r_lat), 32'd4);
    chk("hit_cmd1", 32'(r_cmd[0]), 32'd3);
    chk("hit_cmd2", 32'(r_cmd[1]), 32'd3);
    chk("hit_cmd3", 32'(r_cmd[2]), 32'd0);
    chk("hit_pa", 32'(r_pa), 32'hA5);
    chk("hit_flt", 32'(r_flt), 32'd0);
    chk("hit_miss", 32'(miss_cnt), 32'd0);

    do_lookup(1, 8'h77);
    chk("miss_pa", 32'(r_pa), 32'd0);
    chk("miss_flt", 32'(r_flt), 32'd1);
    chk("miss_cnt1", 32'(miss_cnt), 32'd1);

    m0 = n_mnt;
    do_mnt(1'b0, 8'h30, 8'h5C);
    chk("ins30_once", 32'(n_mnt - m0), 32'd1);
    do_lookup(0, 8'h30);
    chk("ins30_pa", 32'(r_pa), 32'h5C);
    chk("ins30_flt", 32'(r_flt), 32'd0);
    m0 = n_mnt;
    do_mnt(1'b1, 8'h30, 8'hFF);
    chk("del_cmd1", 32'(r_cmd[0]), 32'd2);
    chk("del_once", 32'(n_mnt - m0), 32'd1);
    chk("pa_hold", 32'(lk_paddr), 32'h5C);
    chk("flt_hold", 32'(lk_fault), 32'd0);
    do_lookup(1, 8'h30);
    chk("del30_flt", 32'(r_flt), 32'd1);
    chk("del30_pa", 32'(r_pa), 32'd0);
    chk("miss_cnt2", 32'(miss_cnt), 32'd2);

    // Fairness from reset: both ports held, grants alternate starting at port 0.
    do_reset();
    @(posedge clk); #1;
    log_id.delete(); log_cyc.delete(); log_flt.delete();
    lk_key0 = 8'h12; lk_key1 = 8'h77; lk_req = 2'b11;
    n = 0;
    while (log_id.size() < 4 && n < 200) begin @(posedge clk); #1; n++; end
    lk_req = 2'b00;
    chk("fair_n", 32'(log_id.size()), 32'd4);
    for (int i = 0; i < 4 && i < log_id.size(); i++) begin
      chk("fair_port", 32'(log_id[i]), 32'(i % 2));
      chk("fair_flt", 32'(log_flt[i]), 32'(i % 2));
      if (i > 0) chk("fair_gap", 32'(log_cyc[i] - log_cyc[i-1]), 32'd5);
    end
    exp_miss += 2;
    chk("fair_miss", 32'(miss_cnt), 32'(exp_miss));

    // Burst guard: four maintenance grants, then the pending lookup, then maintenance again.
    log_id.delete(); log_cyc.delete(); log_flt.delete();
    mnt_op = 1'b0; mnt_key = 8'h40; mnt_data = 8'h11; mnt_req = 1'b1;
    lk_key0 = 8'h12; lk_req = 2'b01;
    n = 0;
    while (log_id.size() < 6 && n < 300) begin
      @(posedge clk); #1; n++;
      if (log_id.size() >= 5) lk_req = 2'b00;
    end
    mnt_req = 1'b0; lk_req = 2'b00;
    ref_dat[8'h40] = 8'h11;
    chk("burst_n", 32'(log_id.size()), 32'd6);
    for (int i = 0; i < 6 && i < log_id.size(); i++)
      chk("burst_seq", 32'(log_id[i]), (i == 4) ? 32'd0 : 32'd2);
    chk("burst_pa", 32'(lk_paddr), 32'hA5);

    // Watchdog: CAM stops signalling ready after a read; a present key still faults.
    chk("wd_err0", 32'(err), 32'd0);
    hang_mode = 1'b1;
    do_lookup(0, 8'h12);
    hang_mode = 1'b0;
    chk("wd_lat", 32'(r_lat), 32'd18);
    chk("wd_flt", 32'(r_flt), 32'd1);
    chk("wd_pa", 32'(r_pa), 32'd0);
    chk("wd_err", 32'(err), 32'd1);
    exp_miss++;
    chk("wd_miss", 32'(miss_cnt), 32'(exp_miss));

    // Reset in the middle of ISSUE: outputs clear without a clock edge, no ack follows.
    @(posedge clk); #1;
    lk_key0 = 8'h12; lk_req = 2'b01;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_cmd", 32'(cam_cmd), 32'd3);
    l0 = n_lk;
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    repeat (3) @(posedge clk);
    #1 lk_req = 2'b00;
    rst = 1'b0;
    exp_miss = 0;
    repeat (8) @(posedge clk);
    #1;
    chk("midrst_noack", 32'(n_lk - l0), 32'd0);

    // Randomized mix against the key->data map, with random CAM ready stalls.
    rand_mode = 1'b1;
    m0 = n_mnt; l0 = n_lk;
    k = 0; p = 0;
    for (int t = 0; t < 40; t++) begin
      key = keys[$urandom_range(0, 7)];
      case ($urandom_range(0, 3))
        0, 1: begin
          p = $urandom_range(0, 1);
          do_lookup(p, key);
          k++;
          if (ref_dat.exists(key)) begin
            chk("rnd_pa", 32'(r_pa), 32'(ref_dat[key]));
            chk("rnd_flt", 32'(r_flt), 32'd0);
          end else begin
            chk("rnd_pa_f", 32'(r_pa), 32'd0);
            chk("rnd_flt_f", 32'(r_flt), 32'd1);
            exp_miss++;
          end
        end
        2: begin
          dat = 8'($urandom);
          do_mnt(1'b0, key, dat);
        end
        default: do_mnt(1'b1, key, 8'h00);
      endcase
    end
    rand_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rnd_miss", 32'(miss_cnt), 32'(exp_miss));
    chk("rnd_err", 32'(err), 32'd0);
    chk("rnd_lk_acks", 32'(n_lk - l0), 32'(k));
    chk("rnd_mnt_acks", 32'(n_mnt - m0), 32'(40 - k));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit reached");
  end

endmodule

// File: doc/cam_sched.md
# cam_sched

Request scheduler that shares the 32-entry key/data CAM (virtual-to-physical translation store) between two lookup requesters and one maintenance (insert/delete) requester. It grants one requester at a time. It drives the CAM command/key/data inputs for a fixed hold window, samples the CAM result, and returns a registered response with a one-cycle acknowledge. It also guards against CAM hang (watchdog) and counts page faults. It sits directly in front of the CAM; requesters never drive the CAM themselves.

## Interface
- RD_WAIT, 2: cycles CAM cmd is held for a read (≥1); result sampled on last held cycle
- WR_WAIT, 2: cycles CAM cmd is held for insert/delete (≥1)
- MNT_BURST, 4: max consecutive maintenance grants while a lookup is pending (≥1)
- TIMEOUT, 15: max RELEASE cycles waiting for cam_outrdy (≥1)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- lk_req[1:0]  in  2  lookup request per port; level, held until that port's ack
- lk_key0, lk_key1  in  8 each  virtual key per port
- lk_ack[1:0]  out  2  one-cycle response strobe per port
- lk_paddr  out  8  physical data; valid with lk_ack
- lk_fault  out  1  page fault (miss or timeout); valid with lk_ack
- mnt_req  in  1  maintenance request; level, held until mnt_ack
- mnt_op  in  1  0 = insert, 1 = delete
- mnt_key, mnt_data  in  8 each  key / data for maintenance
- mnt_ack  out  1  one-cycle completion strobe
- cam_cmd  out  2  00 NOP, 01 INS, 10 DEL, 11 RD
- cam_key, cam_datain  out  8 each  to CAM
- cam_dataout  in  8  from CAM
- cam_outvalid, cam_pagefault, cam_outrdy  in  1 each  from CAM
- err  out  1  sticky watchdog flag; cleared only by rst
- miss_cnt  out  16  lookup faults, saturating at 16'hFFFF

## Operation
- The state machine has four states: IDLE, ISSUE, RELEASE, RESP. Reset state is IDLE.
- IDLE: a grant occurs when cam_outrdy=1 and any request is pending. At the grant edge, latch the requester, op, key and data. Go to ISSUE.
- Arbitration:
  - Maintenance has priority, except that after MNT_BURST consecutive maintenance grants, a pending lookup wins.
  - Any lookup grant clears the burst counter.
  - Between lookups, grant round-robin. rr_last holds the last lookup port granted and resets to 1, so port 0 wins first. When both ports request, grant !rr_last.
- ISSUE: drive cam_cmd = op (RD for lookups), cam_key and cam_datain (datain = 0 for RD/DEL) for RD_WAIT or WR_WAIT cycles.
  - For RD, on the last held cycle, latch cam_dataout and cam_outvalid.
  - Hit = cam_outvalid=1. Miss = cam_outvalid=0, regardless of cam_pagefault.
- RELEASE: drive cam_cmd = NOP and hold it for at least one cycle. Leave when cam_outrdy=1 is sampled with the NOP cycle count ≥1.
  - If TIMEOUT cycles pass without cam_outrdy, set err and leave anyway.
  - A timed-out lookup reports fault=1, paddr=0.
- RESP: one cycle.
  - Pulse the ack of the granted requester.
  - For lookups, drive lk_paddr (0 on fault) and lk_fault.
  - On lookup fault, increment miss_cnt (saturating).
  - Then go to IDLE. No grant is made during RESP, so a requester's still-high req is not re-granted.
- Requests arriving or dropping mid-operation do not affect the granted transaction. Dropping req before ack is illegal and its behaviour is undefined.
- rst mid-operation: all state is abandoned immediately and no ack is issued.

## Timing
- Reset values: cam_cmd=00; cam_key=0; cam_datain=0; lk_ack=0; mnt_ack=0; lk_paddr=0; lk_fault=0; err=0; miss_cnt=0. Burst counter=0; rr_last=1.
- All outputs are registered.
- Lookup latency with the CAM ready: the grant is sampled at edge 0.
  - cam_cmd=RD during cycles 1..RD_WAIT.
  - NOP in cycle RD_WAIT+1.
  - Ack in cycle RD_WAIT+2, which is cycle 4 at the defaults.
- Maintenance latency: the same timing with WR_WAIT.
- Back-to-back throughput: one transaction per WAIT+3 cycles (5 at the defaults).
- lk_paddr and lk_fault hold their values until the next lookup RESP.

## Test plan
- Lookup hit: CAM preloaded with key 0x12 → data 0xA5. Assert lk_req[0] with key 0x12. Required: lk_ack[0] 4 cycles after the grant edge, lk_paddr=0xA5, lk_fault=0, miss_cnt unchanged.
- Miss: port 1 looks up key 0x77 (not present). Required: lk_ack[1], lk_fault=1, lk_paddr=0, miss_cnt=1.
- Insert then delete: insert mnt key 0x30 / data 0x5C, then look up 0x30 → hit 0x5C. Delete 0x30, then look up 0x30 → fault. Each maintenance operation receives exactly one mnt_ack.
- Fairness: lk_req=2'b11 held continuously. Required: grants alternate 0,1,0,1, with the first grant to port 0.
- Burst guard: mnt_req held high with lk_req[0] pending. Required: 4 mnt_acks, then lk_ack[0], then maintenance resumes.
- Watchdog: CAM model holds cam_outrdy=0 after a RD. Required: after 15 RELEASE cycles, err=1, lk_ack with lk_fault=1. Apply rst mid-ISSUE: all outputs return to their reset values asynchronously.
